pc_flow_ctrl: RTL and testbench

Multicycle PC sequencing controller: the block that drives the PC-source mux select and the PC/EPC write enables. It sequences each instruction through fetch, decode and execute, and resolves branches, jumps, JR and RTE. It also runs the exception entry sequence, which saves the EPC and jumps to a vector fetched from memory. It sits between the main control unit and the PC/EPC datapath; its `pc_src` encoding matches the PC-source mux: 00 EPC, 01 ALU result, 10 ALUOut, 11 jump concat.

---
 rtl/pc_flow_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pc_flow_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pc_flow_ctrl.sv
// Multicycle PC sequencing controller: drives the PC-source mux select and the
// PC/EPC write enables through fetch, decode, execute and exception entry.
module pc_flow_ctrl #(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] instr_class,
   input  logic       alu_zero,
   input  logic       ovf,
   input  logic       div0,
   input  logic       exec_done,
   output logic [1:0] pc_src,
   output logic       pc_write,
   output logic       epc_write,
   output logic       mem_read,
   output logic       addr_vec,
   output logic [1:0] vec_sel,
   output logic       alu_pc_minus4,
   output logic       alu_target_en,
   output logic [1:0] exc_cause,
   output logic       instr_done
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned CLS_W = 3;
   localparam int unsigned SRC_W = 2;
   localparam int unsigned CAU_W = 2;

   localparam bit               HAS_WAIT  = (MEM_WAIT != 0);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

   localparam logic [CLS_W-1:0] CLS_SEQ = 3'b000;
   localparam logic [CLS_W-1:0] CLS_BEQ = 3'b001;
   localparam logic [CLS_W-1:0] CLS_BNE = 3'b010;
   localparam logic [CLS_W-1:0] CLS_J   = 3'b011;
   localparam logic [CLS_W-1:0] CLS_JR  = 3'b100;
   localparam logic [CLS_W-1:0] CLS_RTE = 3'b101;

   localparam logic [SRC_W-1:0] SRC_EPC  = 2'b00;
   localparam logic [SRC_W-1:0] SRC_ALU  = 2'b01;
   localparam logic [SRC_W-1:0] SRC_OUT  = 2'b10;
   localparam logic [SRC_W-1:0] SRC_JCAT = 2'b11;

   localparam logic [CAU_W-1:0] CAUSE_NONE = 2'b00;
   localparam logic [CAU_W-1:0] CAUSE_ILL  = 2'b01;
   localparam logic [CAU_W-1:0] CAUSE_OVF  = 2'b10;
   localparam logic [CAU_W-1:0] CAUSE_DIV0 = 2'b11;

   typedef enum logic [2:0] {
      S_FETCH,
      S_FETCH_WAIT,
      S_DECODE,
      S_EXEC,
      S_EXC_EPC,
      S_EXC_VEC,
      S_EXC_WAIT,
      S_EXC_JUMP
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CLS_W-1:0]   class_q, class_d;
   logic [CAU_W-1:0]   cause_q, cause_d;

   logic               in_exec_c;
   logic               exc_hit_c;
   logic [CAU_W-1:0]   exc_code_c;
   logic               exec_last_c;
   logic               illegal_c;

   // Same-cycle exception detection while executing; ovf outranks div0
   assign in_exec_c   = (state_q == S_EXEC);
   assign exc_hit_c   = in_exec_c && (ovf || div0);
   assign exc_code_c  = ovf ? CAUSE_OVF : CAUSE_DIV0;
   assign exec_last_c = (class_q == CLS_SEQ) ? exec_done : 1'b1;
   assign illegal_c   = (instr_class[2:1] == 2'b11);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         class_q <= CLS_SEQ;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         class_q <= class_d;
         cause_q <= cause_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      class_d = class_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH: begin
            if (HAS_WAIT) begin
               state_d = S_FETCH_WAIT;
               cnt_d   = WAIT_INIT;
            end else begin
               state_d = S_DECODE;
            end
         end
         S_FETCH_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DECODE: begin
            class_d = instr_class;
            if (illegal_c) begin
               state_d = S_EXC_EPC;
               cause_d = CAUSE_ILL;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (exc_hit_c) begin
               state_d = S_EXC_EPC;
               cause_d = exc_code_c;
            end else if (exec_last_c) begin
               state_d = S_FETCH;
               if (class_q == CLS_RTE) begin
                  cause_d = CAUSE_NONE;
               end
            end
         end
         S_EXC_EPC: begin
            state_d = S_EXC_VEC;
         end
         S_EXC_VEC: begin
            if (HAS_WAIT) begin
               state_d = S_EXC_WAIT;
               cnt_d   = WAIT_INIT;
            end else begin
               state_d = S_EXC_JUMP;
            end
         end
         S_EXC_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_EXC_JUMP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_EXC_JUMP: begin
            state_d = S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Output decode; everything is forced to idle values while reset is held
   always_comb begin
      pc_src        = SRC_ALU;
      pc_write      = 1'b0;
      epc_write     = 1'b0;
      mem_read      = 1'b0;
      addr_vec      = 1'b0;
      vec_sel       = CAUSE_NONE;
      alu_pc_minus4 = 1'b0;
      alu_target_en = 1'b0;
      instr_done    = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read = 1'b1;
               pc_write = 1'b1;
            end
            S_DECODE: begin
               alu_target_en = 1'b1;
            end
            S_EXEC: begin
               case (class_q)
                  CLS_BEQ: begin
                     pc_src   = SRC_OUT;
                     pc_write = alu_zero;
                  end
                  CLS_BNE: begin
                     pc_src   = SRC_OUT;
                     pc_write = !alu_zero;
                  end
                  CLS_J: begin
                     pc_src   = SRC_JCAT;
                     pc_write = 1'b1;
                  end
                  CLS_JR: begin
                     pc_src   = SRC_ALU;
                     pc_write = 1'b1;
                  end
                  CLS_RTE: begin
                     pc_src   = SRC_EPC;
                     pc_write = 1'b1;
                  end
                  default: begin
                     pc_write = 1'b0;
                  end
               endcase
               if (exc_hit_c) begin
                  pc_write = 1'b0;
               end
               instr_done = exec_last_c && !exc_hit_c;
            end
            S_EXC_EPC: begin
               alu_pc_minus4 = 1'b1;
               epc_write     = 1'b1;
            end
            S_EXC_VEC: begin
               mem_read = 1'b1;
               addr_vec = 1'b1;
               vec_sel  = cause_q;
            end
            S_EXC_JUMP: begin
               pc_src     = SRC_OUT;
               pc_write   = 1'b1;
               instr_done = 1'b1;
            end
            default: begin
               pc_src = SRC_ALU;
            end
         endcase
      end
   end

   assign exc_cause = cause_q;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for pc_flow_ctrl: one instance with two memory wait cycles and
// one with none; each is held in reset while the other is exercised.
module tb_pc_flow_ctrl;

   localparam logic [2:0] C_SEQ = 3'b000;
   localparam logic [2:0] C_BEQ = 3'b001;
   localparam logic [2:0] C_BNE = 3'b010;
   localparam logic [2:0] C_J   = 3'b011;
   localparam logic [2:0] C_RTE = 3'b101;
   localparam logic [2:0] C_ILL = 3'b110;

   logic       clk = 1'b0;
   logic       reset2, reset0;
   logic [2:0] cls;
   logic       az, ovf, div0, ed;

   logic [1:0] pc_src2, vec_sel2, cause2, pc_src0, vec_sel0, cause0;
   logic       pw2, ew2, mr2, av2, m42, te2, dn2;
   logic       pw0, ew0, mr0, av0, m40, te0, dn0;
   logic [12:0] obs2, obs0;

   int n_run  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pc_flow_ctrl #(.MEM_WAIT(2)) dut2 (
      .clk(clk), .reset(reset2), .instr_class(cls), .alu_zero(az), .ovf(ovf),
      .div0(div0), .exec_done(ed), .pc_src(pc_src2), .pc_write(pw2),
      .epc_write(ew2), .mem_read(mr2), .addr_vec(av2), .vec_sel(vec_sel2),
      .alu_pc_minus4(m42), .alu_target_en(te2), .exc_cause(cause2),
      .instr_done(dn2)
   );

   pc_flow_ctrl #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .reset(reset0), .instr_class(cls), .alu_zero(az), .ovf(ovf),
      .div0(div0), .exec_done(ed), .pc_src(pc_src0), .pc_write(pw0),
      .epc_write(ew0), .mem_read(mr0), .addr_vec(av0), .vec_sel(vec_sel0),
      .alu_pc_minus4(m40), .alu_target_en(te0), .exc_cause(cause0),
      .instr_done(dn0)
   );

   assign obs2 = {pc_src2, pw2, ew2, mr2, av2, vec_sel2, m42, te2, dn2, cause2};
   assign obs0 = {pc_src0, pw0, ew0, mr0, av0, vec_sel0, m40, te0, dn0, cause0};

   // Packed view: {pc_src, pc_write, epc_write, mem_read, addr_vec, vec_sel, pc-4, target_en, done, cause}
   function automatic logic [12:0] ov(input logic [1:0] src, input logic pw, ew, mr, av,
                                      input logic [1:0] vs, input logic m4, te, dn,
                                      input logic [1:0] cz);
      return {src, pw, ew, mr, av, vs, m4, te, dn, cz};
   endfunction

   function automatic logic [12:0] o_rst();
      return ov(2'b01, 0, 0, 0, 0, 2'b00, 0, 0, 0, 2'b00);
   endfunction
   function automatic logic [12:0] o_fetch(input logic [1:0] cz);
      return ov(2'b01, 1, 0, 1, 0, 2'b00, 0, 0, 0, cz);
   endfunction
   function automatic logic [12:0] o_wait(input logic [1:0] cz);
      return ov(2'b01, 0, 0, 0, 0, 2'b00, 0, 0, 0, cz);
   endfunction
   function automatic logic [12:0] o_dec(input logic [1:0] cz);
      return ov(2'b01, 0, 0, 0, 0, 2'b00, 0, 1, 0, cz);
   endfunction
   function automatic logic [12:0] o_exec(input logic [1:0] src, input logic pw, dn,
                                          input logic [1:0] cz);
      return ov(src, pw, 0, 0, 0, 2'b00, 0, 0, dn, cz);
   endfunction
   function automatic logic [12:0] o_epc(input logic [1:0] cz);
      return ov(2'b01, 0, 1, 0, 0, 2'b00, 1, 0, 0, cz);
   endfunction
   function automatic logic [12:0] o_vec(input logic [1:0] cz);
      return ov(2'b01, 0, 0, 1, 1, cz, 0, 0, 0, cz);
   endfunction
   function automatic logic [12:0] o_jump(input logic [1:0] cz);
      return ov(2'b10, 1, 0, 0, 0, 2'b00, 0, 0, 1, cz);
   endfunction

   task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge, drive inputs, let outputs settle
   task automatic step(input logic [2:0] c, input logic z, o, d, e);
      @(negedge clk);
      cls  = c;
      az   = z;
      ovf  = o;
      div0 = d;
      ed   = e;
      #1;
   endtask

   // FETCH, two wait cycles and DECODE on the MEM_WAIT=2 instance
   task automatic pre2(input string tag, input logic [2:0] c, input logic [1:0] cz);
      step(C_SEQ, 0, 0, 0, 0); check({tag, "_fetch"}, obs2, o_fetch(cz));
      step(C_SEQ, 0, 0, 0, 0); check({tag, "_w1"},    obs2, o_wait(cz));
      step(C_SEQ, 0, 0, 0, 0); check({tag, "_w2"},    obs2, o_wait(cz));
      step(c,     0, 0, 0, 0); check({tag, "_dec"},   obs2, o_dec(cz));
   endtask

   initial begin
      reset2 = 1'b0;
      reset0 = 1'b0;
      cls = C_SEQ; az = 0; ovf = 0; div0 = 0; ed = 0;

      repeat (2) @(negedge clk);
      #1;
      check("rst2", obs2, o_rst());
      check("rst0", obs0, o_rst());

      @(negedge clk); reset2 = 1'b1; #1;
      check("rel_fetch", obs2, o_fetch(2'b00));
      step(C_SEQ, 0, 0, 0, 0); check("beq1_w1", obs2, o_wait(2'b00));
      step(C_SEQ, 0, 0, 0, 0); check("beq1_w2", obs2, o_wait(2'b00));
      step(C_BEQ, 0, 0, 0, 0); check("beq1_dec", obs2, o_dec(2'b00));
      step(C_BEQ, 1, 0, 0, 0); check("beq_taken", obs2, o_exec(2'b10, 1, 1, 2'b00));

      pre2("beq2", C_BEQ, 2'b00);
      step(C_BEQ, 0, 0, 0, 0); check("beq_not", obs2, o_exec(2'b10, 0, 1, 2'b00));

      pre2("bne", C_BNE, 2'b00);
      step(C_BNE, 1, 0, 0, 0); check("bne_not", obs2, o_exec(2'b10, 0, 1, 2'b00));

      // Illegal instruction: full exception entry with two vector wait cycles
      pre2("ill", C_ILL, 2'b00);
      step(C_SEQ, 0, 0, 0, 0); check("ill_epc",  obs2, o_epc(2'b01));
      step(C_ILL, 0, 1, 0, 0); check("ill_vec",  obs2, o_vec(2'b01));
      step(C_SEQ, 0, 0, 1, 0); check("ill_w1",   obs2, o_wait(2'b01));
      step(C_SEQ, 0, 0, 0, 0); check("ill_w2",   obs2, o_wait(2'b01));
      step(C_SEQ, 0, 0, 0, 0); check("ill_jump", obs2, o_jump(2'b01));

      pre2("rte", C_RTE, 2'b01);
      step(C_RTE, 0, 0, 0, 0); check("rte_exec", obs2, o_exec(2'b00, 1, 1, 2'b01));

      // Sequential: ovf+div0 together with exec_done gives cause 10
      pre2("seq", C_SEQ, 2'b00);
      step(C_SEQ, 0, 0, 0, 0); check("seq_e1",   obs2, o_exec(2'b01, 0, 0, 2'b00));
      step(C_SEQ, 0, 0, 0, 0); check("seq_e2",   obs2, o_exec(2'b01, 0, 0, 2'b00));
      step(C_SEQ, 0, 1, 1, 1); check("seq_exc",  obs2, o_exec(2'b01, 0, 0, 2'b00));
      step(C_SEQ, 0, 0, 0, 0); check("seq_epc",  obs2, o_epc(2'b10));
      step(C_SEQ, 0, 0, 0, 0); check("seq_vec",  obs2, o_vec(2'b10));
      step(C_SEQ, 0, 0, 0, 0); check("seq_w1",   obs2, o_wait(2'b10));
      step(C_SEQ, 0, 0, 0, 0); check("seq_w2",   obs2, o_wait(2'b10));
      step(C_SEQ, 0, 0, 0, 0); check("seq_jump", obs2, o_jump(2'b10));

      // Jump hit by div0: pc_write suppressed, cause 11, then reset mid-wait
      pre2("jd0", C_J, 2'b10);
      step(C_J,   0, 0, 1, 0); check("jd0_exec", obs2, o_exec(2'b11, 0, 0, 2'b10));
      step(C_SEQ, 0, 0, 0, 0); check("jd0_epc",  obs2, o_epc(2'b11));
      step(C_SEQ, 0, 0, 0, 0); check("jd0_vec",  obs2, o_vec(2'b11));
      @(negedge clk); reset2 = 1'b0; #1;
      check("rst_mid", obs2, o_rst());
      step(C_SEQ, 0, 0, 0, 0); check("rst_hold", obs2, o_rst());
      @(negedge clk); reset2 = 1'b1; #1;
      check("rst_rel", obs2, o_fetch(2'b00));
      step(C_SEQ, 0, 0, 0, 0); check("rst_w1", obs2, o_wait(2'b00));

      // MEM_WAIT=0 instance
      @(negedge clk); reset2 = 1'b0; reset0 = 1'b1; #1;
      check("m0_fetch", obs0, o_fetch(2'b00));
      step(C_J,   0, 0, 0, 0); check("m0_j_dec",  obs0, o_dec(2'b00));
      step(C_J,   0, 0, 0, 0); check("m0_j_exec", obs0, o_exec(2'b11, 1, 1, 2'b00));
      step(C_SEQ, 0, 0, 0, 0); check("m0_j_next", obs0, o_fetch(2'b00));
      step(C_ILL, 0, 0, 0, 0); check("m0_i_dec",  obs0, o_dec(2'b00));
      step(C_ILL, 0, 1, 0, 0); check("m0_i_epc",  obs0, o_epc(2'b01));
      step(C_ILL, 0, 1, 1, 0); check("m0_i_vec",  obs0, o_vec(2'b01));
      step(C_SEQ, 0, 1, 0, 0); check("m0_i_jump", obs0, o_jump(2'b01));
      step(C_SEQ, 0, 0, 0, 0); check("m0_i_next", obs0, o_fetch(2'b01));
      step(C_SEQ, 0, 0, 0, 0); check("m0_s_dec",  obs0, o_dec(2'b01));
      step(C_SEQ, 1, 0, 0, 0); check("m0_s_e1",   obs0, o_exec(2'b01, 0, 0, 2'b01));
      step(C_SEQ, 1, 0, 0, 1); check("m0_s_e2",   obs0, o_exec(2'b01, 0, 1, 2'b01));
      step(C_SEQ, 0, 0, 0, 0); check("m0_s_next", obs0, o_fetch(2'b01));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
